fetch_pc_unit: RTL

- Fetch-stage program-counter unit that consumes the branch/SLT comparison result (`comp`) and the resolved control-transfer information from execute.
- Owns the PC register and drives a valid/ready request handshake to instruction memory.
- Presents fetched instructions to decode through a registered output plus a one-entry skid buffer.
- Redirects on taken branches/jumps, flushes younger work, and halts on a misaligned target.

---
 rtl/fetch_pc_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC unit: owns the PC, fetches over a valid/ready port and hands
// instructions to decode through an output register backed by one skid entry.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_valid,
  input  logic        is_branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic        comp,
  input  logic [31:0] pc_ex,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        flush,
  output logic        trap,
  output logic [31:0] trap_pc
);

  // state | meaning
  // BOOT  | first cycle after reset release, no request yet
  // REQ   | fetching; request raised when the output stage can take data
  // SKID  | a response is parked in the skid entry, waiting for decode
  // TRAP  | misaligned target seen, fetch stopped until reset
  typedef enum logic [1:0] {BOOT, REQ, SKID, TRAP} state_t;

  state_t      state_q, state_d;
  logic        req_hold_q, req_hold_d;
  logic        drop_q, drop_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] addr_d, if_instr_d, if_pc_d, trap_pc_d;
  logic        if_valid_d, trap_d;
  logic        taken, redirect, can_load, done;
  logic [31:0] jalr_sum, target;

  assign taken    = br_valid & (is_jal | is_jalr | (is_branch & comp));
  assign jalr_sum = rs1 + imm;
  assign target   = is_jalr ? {jalr_sum[31:1], 1'b0} : (pc_ex + imm);
  assign redirect = taken & ~trap;
  assign flush    = redirect;
  assign can_load = ~if_valid | ~stall;
  // once raised, the request is held until memory takes it, whatever stall does
  assign imem_req = (state_q == REQ) & (req_hold_q | can_load);
  assign done     = imem_req & imem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      req_hold_q   <= 1'b0;
      drop_q       <= 1'b0;
      pend_q       <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      imem_addr    <= RESET_PC;
      if_valid     <= 1'b0;
      if_instr     <= NOP_INSTR;
      if_pc        <= '0;
      trap         <= 1'b0;
      trap_pc      <= '0;
    end else begin
      state_q      <= state_d;
      req_hold_q   <= req_hold_d;
      drop_q       <= drop_d;
      pend_q       <= pend_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      imem_addr    <= addr_d;
      if_valid     <= if_valid_d;
      if_instr     <= if_instr_d;
      if_pc        <= if_pc_d;
      trap         <= trap_d;
      trap_pc      <= trap_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    req_hold_d   = req_hold_q;
    drop_d       = drop_q;
    pend_d       = pend_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    addr_d       = imem_addr;
    if_valid_d   = if_valid & stall;
    if_instr_d   = if_instr;
    if_pc_d      = if_pc;
    trap_d       = trap;
    trap_pc_d    = trap_pc;

    case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        if (done) begin
          req_hold_d = 1'b0;
          if (drop_q) begin
            drop_d = 1'b0;
            addr_d = pend_q;
          end else begin
            addr_d = imem_addr + 32'd4;
            if (can_load) begin
              if_valid_d = 1'b1;
              if_instr_d = imem_rdata;
              if_pc_d    = imem_addr;
            end else begin
              skid_instr_d = imem_rdata;
              skid_pc_d    = imem_addr;
              state_d      = SKID;
            end
          end
        end else if (imem_req) begin
          req_hold_d = 1'b1;
        end
      end
      SKID: begin
        if (!stall) begin
          if_valid_d = 1'b1;
          if_instr_d = skid_instr_q;
          if_pc_d    = skid_pc_q;
          state_d    = REQ;
        end
      end
      TRAP: state_d = TRAP;
      default: state_d = BOOT;
    endcase

    // a taken transfer overrides stall, skid drain and any normal completion
    if (redirect) begin
      if_valid_d = 1'b0;
      if_instr_d = if_instr;
      if_pc_d    = if_pc;
      if (target[1]) begin
        trap_d     = 1'b1;
        trap_pc_d  = target;
        state_d    = TRAP;
        req_hold_d = 1'b0;
        drop_d     = 1'b0;
        addr_d     = imem_addr;
      end else begin
        state_d = REQ;
        if (imem_req & ~imem_ready) begin
          drop_d = 1'b1;
          pend_d = target;
          addr_d = imem_addr;
        end else begin
          drop_d = 1'b0;
          addr_d = target;
        end
      end
    end
  end

endmodule
